// File: rtl/tone_decoder.sv
// tone_decoder: measures the period of an external square-wave tone and
// turns it into a note index from the player's 15-note table. The decoded
// note, its solfege LED code and the high flag change only after several
// consecutive periods of the same class. If the tone stops, the outputs
// fall back to rest (note 0) after a silence timeout.
`timescale 1ns/1ps

module tone_decoder #(
    parameter int unsigned STABLE_CNT  = 3,     // same-class periods needed to change note (1..7)
    parameter int unsigned TIMEOUT_CYC = 8192,  // cycles without a rising edge before silence
    parameter int unsigned MIN_PER     = 880,   // shortest accepted period
    parameter int unsigned MAX_PER     = 4200   // longest accepted period
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tone_in,
    output logic [3:0]  note,
    output logic [3:0]  code,
    output logic        high,
    output logic        note_valid,
    output logic [15:0] period,
    output logic        o_dbg_state     // 0 = IDLE, 1 = MEASURE
);

    // note_valid protocol: it is a one-cycle pulse with no back-pressure.
    // It is high on exactly the cycle where note/code/high first show
    // their new values. It fires at most once per rising edge or timeout,
    // and it never stays high for two cycles in a row.

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_MEASURE = 1'b1
    } state_t;

    // Nominal period of each note, index 0 = note 1 ... index 14 = note 15
    localparam logic [15:0] NOM [15] = '{
        16'd3817, 16'd3401, 16'd3030, 16'd2865, 16'd2551, 16'd2273, 16'd2024,
        16'd1912, 16'd1703, 16'd1517, 16'd1433, 16'd1276, 16'd1136, 16'd1012,
        16'd955
    };

    localparam logic [15:0] LP_MIN     = 16'(MIN_PER);
    localparam logic [15:0] LP_MAX     = 16'(MAX_PER);
    localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_CYC);
    localparam logic [2:0]  LP_STABLE  = 3'(STABLE_CNT);

    // Class 0 means out of range. Otherwise the result is the nearest note.
    // Each boundary is the truncated midpoint between two neighbouring
    // nominals. A period equal to a boundary belongs to the higher index,
    // because the comparison is a strict "longer than".
    function automatic logic [3:0] classify(input logic [15:0] p);
        logic [3:0] cls;
        int         b;
        cls = 4'd15;
        if (p < LP_MIN || p > LP_MAX) begin
            cls = 4'd0;
        end else begin
            // Walk from short to long periods, so the lowest matching index wins
            for (int i = 13; i >= 0; i--) begin
                b = (int'(NOM[i]) + int'(NOM[i+1])) / 2;
                if (int'(p) > b) begin
                    cls = 4'(i + 1);
                end
            end
        end
        return cls;
    endfunction

    // Solfege LED code: low and mid octaves map onto 1..7, and high C shows as 1
    function automatic logic [3:0] code_of(input logic [3:0] n);
        logic [3:0] c;
        c = 4'd0;
        if (n == 4'd15) begin
            c = 4'd1;
        end else if (n >= 4'd8) begin
            c = n - 4'd7;
        end else begin
            c = n;
        end
        return c;
    endfunction

    // Registers
    logic        r_sync1, r_sync2, r_sync3;
    logic [15:0] r_cnt;
    state_t      r_state;
    logic [15:0] r_period;
    logic [3:0]  r_cand;
    logic [2:0]  r_stab;
    logic [3:0]  r_note;
    logic [3:0]  r_code;
    logic        r_high;
    logic        r_nv;

    // Next-state wires
    logic        w_rise;
    logic [3:0]  w_class;
    state_t      w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic [15:0] w_period_nxt;
    logic [3:0]  w_cand_nxt;
    logic [2:0]  w_stab_nxt;
    logic [3:0]  w_note_nxt;
    logic        w_nv_nxt;

    assign w_rise  = r_sync2 & ~r_sync3;
    // At a rising edge the running count is exactly the finished period
    assign w_class = classify(r_cnt);

    // Two-flop synchronizer plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= tone_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Next-state logic: period capture, stability tracking, note decision, timeout
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
        w_period_nxt = r_period;
        w_cand_nxt   = r_cand;
        w_stab_nxt   = r_stab;
        w_note_nxt   = r_note;
        w_nv_nxt     = 1'b0;

        if (w_rise) begin
            w_cnt_nxt = 16'd1;
        end

        case (r_state)
            S_IDLE: begin
                // The first edge only starts the measurement; it yields no period
                if (w_rise) begin
                    w_state_nxt = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (w_rise) begin
                    w_period_nxt = r_cnt;
                    if (w_class != 4'd0 && w_class == r_cand) begin
                        w_stab_nxt = (r_stab < LP_STABLE) ? r_stab + 3'd1 : r_stab;
                    end else if (w_class == 4'd0) begin
                        w_cand_nxt = 4'd0;
                        w_stab_nxt = 3'd0;
                    end else begin
                        w_cand_nxt = w_class;
                        w_stab_nxt = 3'd1;
                    end
                    // A candidate that is already the published note needs no change
                    if (w_stab_nxt >= LP_STABLE && w_cand_nxt != 4'd0 &&
                        w_cand_nxt != r_note) begin
                        w_note_nxt = w_cand_nxt;
                        w_nv_nxt   = 1'b1;
                    end
                end else if (r_cnt >= LP_TIMEOUT) begin
                    // Silence: forget the candidate and fall back to rest.
                    // The last measured period stays visible.
                    w_state_nxt = S_IDLE;
                    w_cand_nxt  = 4'd0;
                    w_stab_nxt  = 3'd0;
                    if (r_note != 4'd0) begin
                        w_note_nxt = 4'd0;
                        w_nv_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= 16'd0;
            r_period <= 16'd0;
            r_cand   <= 4'd0;
            r_stab   <= 3'd0;
            r_note   <= 4'd0;
            r_code   <= 4'd0;
            r_high   <= 1'b0;
            r_nv     <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_period <= w_period_nxt;
            r_cand   <= w_cand_nxt;
            r_stab   <= w_stab_nxt;
            r_note   <= w_note_nxt;
            r_code   <= code_of(w_note_nxt);
            r_high   <= (w_note_nxt >= 4'd8);
            r_nv     <= w_nv_nxt;
        end
    end

    assign note        = r_note;
    assign code        = r_code;
    assign high        = r_high;
    assign note_valid  = r_nv;
    assign period      = r_period;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tone_decoder.sv
// tb_tone_decoder: directed tone sequences with hand-computed note, code,
// high, period and pulse-count expectations for tone_decoder.
`timescale 1ns/1ps

module tb_tone_decoder;

    localparam int TO = 5000;  // silence timeout used for this bench

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        tone_in;
    logic [3:0]  note;
    logic [3:0]  code;
    logic        high;
    logic        note_valid;
    logic [15:0] period;
    logic        dbg_state;

    always #500 clk = ~clk;  // 1 MHz

    tone_decoder #(
        .STABLE_CNT (3),
        .TIMEOUT_CYC(TO),
        .MIN_PER    (880),
        .MAX_PER    (4200)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tone_in    (tone_in),
        .note       (note),
        .code       (code),
        .high       (high),
        .note_valid (note_valid),
        .period     (period),
        .o_dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks   = 0;
    int n_pass     = 0;
    int pulses     = 0;
    int exp_pulses = 0;
    int b2b        = 0;
    logic prev_nv  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Count note_valid pulses and any pulse that lasts two cycles
    always @(negedge clk) begin
        if (note_valid === 1'b1) begin
            pulses++;
            if (prev_nv) b2b++;
        end
        prev_nv = note_valid;
    end

    // ---------------- driver tasks ----------------
    // Pin is low on entry. Raise it and wait until the DUT has acted on the edge.
    task automatic ref_edge();
        tone_in = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Entry point: the pin rose 3 negedges ago. This task completes one
    // period of p cycles, raises the pin again and returns once that
    // rising edge has been processed.
    task automatic tone_period(input int p);
        repeat (p / 2 - 3) @(negedge clk);
        tone_in = 1'b0;
        repeat (p - p / 2) @(negedge clk);
        tone_in = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [3:0] n, input logic [3:0] c,
                              input logic h, input logic nv);
        #1;
        check({tag, ".note"}, note, n);
        check({tag, ".code"}, code, c);
        check({tag, ".high"}, high, h);
        check({tag, ".nv"}, note_valid, nv);
        check({tag, ".pulses"}, pulses, exp_pulses);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n   = 1'b0;
        tone_in = 1'b0;
        repeat (3) @(negedge clk);
        expect_out("reset", 4'd0, 4'd0, 1'b0, 1'b0);
        check("reset.period", period, 16'd0);
        check("reset.state", dbg_state, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: 440 Hz tone locks after a reference edge and three periods
        ref_edge();
        expect_out("t1_ref", 4'd0, 4'd0, 1'b0, 1'b0);
        check("t1_ref.state", dbg_state, 1'b1);
        check("t1_ref.period", period, 16'd0);
        tone_period(2273);
        tone_period(2273);
        expect_out("t1_p2", 4'd0, 4'd0, 1'b0, 1'b0);
        tone_period(2273);
        exp_pulses = 1;
        expect_out("t1_lock", 4'd6, 4'd6, 1'b0, 1'b1);
        check("t1_lock.period", period, 16'd2273);

        // 2: change directly to 1136
        tone_period(1136);
        tone_period(1136);
        expect_out("t2_p2", 4'd6, 4'd6, 1'b0, 1'b0);
        check("t2_p2.period", period, 16'd1136);
        tone_period(1136);
        exp_pulses = 2;
        expect_out("t2_lock", 4'd13, 4'd6, 1'b1, 1'b1);

        // 3: boundary periods around the 7/8 midpoint and the 14/15 midpoint
        for (int i = 0; i < 3; i++) tone_period(1968);
        exp_pulses = 3;
        expect_out("t3_1968", 4'd8, 4'd1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tone_period(1969);
        exp_pulses = 4;
        expect_out("t3_1969", 4'd7, 4'd7, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tone_period(983);
        exp_pulses = 5;
        expect_out("t3_983", 4'd15, 4'd1, 1'b1, 1'b1);

        // 4: an out-of-range period restarts stability
        tone_period(3817);
        tone_period(3817);
        expect_out("t4_p2", 4'd15, 4'd1, 1'b1, 1'b0);
        tone_period(700);
        expect_out("t4_oor", 4'd15, 4'd1, 1'b1, 1'b0);
        check("t4_oor.period", period, 16'd700);
        tone_period(3817);
        tone_period(3817);
        expect_out("t4_p5", 4'd15, 4'd1, 1'b1, 1'b0);
        tone_period(3817);
        exp_pulses = 6;
        expect_out("t4_lock", 4'd1, 4'd1, 1'b0, 1'b1);

        // 5: silence with the pin low, restart, then silence with the pin high
        for (int i = 0; i < 3; i++) tone_period(1703);
        exp_pulses = 7;
        expect_out("t5_lock", 4'd9, 4'd2, 1'b1, 1'b1);
        tone_in = 1'b0;
        repeat (TO - 1) @(negedge clk);
        expect_out("t5_pre_to", 4'd9, 4'd2, 1'b1, 1'b0);
        @(negedge clk);
        exp_pulses = 8;
        expect_out("t5_to", 4'd0, 4'd0, 1'b0, 1'b1);
        check("t5_to.period", period, 16'd1703);
        check("t5_to.state", dbg_state, 1'b0);
        repeat (10) @(negedge clk);
        ref_edge();
        tone_period(1703);
        tone_period(1703);
        expect_out("t5_re_p2", 4'd0, 4'd0, 1'b0, 1'b0);
        tone_period(1703);
        exp_pulses = 9;
        expect_out("t5_relock", 4'd9, 4'd2, 1'b1, 1'b1);
        repeat (TO - 1) @(negedge clk);
        expect_out("t5_hi_pre", 4'd9, 4'd2, 1'b1, 1'b0);
        @(negedge clk);
        exp_pulses = 10;
        expect_out("t5_hi_to", 4'd0, 4'd0, 1'b0, 1'b1);

        // 6: reset in the middle of a period
        tone_in = 1'b0;
        repeat (10) @(negedge clk);
        ref_edge();
        for (int i = 0; i < 3; i++) tone_period(1276);
        exp_pulses = 11;
        expect_out("t6_lock", 4'd12, 4'd5, 1'b1, 1'b1);
        repeat (300) @(negedge clk);
        tone_in = 1'b0;
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        expect_out("t6_rst", 4'd0, 4'd0, 1'b0, 1'b0);
        check("t6_rst.period", period, 16'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        expect_out("t6_rel", 4'd0, 4'd0, 1'b0, 1'b0);
        check("t6_rel.state", dbg_state, 1'b0);
        ref_edge();
        tone_period(1276);
        tone_period(1276);
        expect_out("t6_p2", 4'd0, 4'd0, 1'b0, 1'b0);
        tone_period(1276);
        exp_pulses = 12;
        expect_out("t6_relock", 4'd12, 4'd5, 1'b1, 1'b1);
        check("t6_relock.period", period, 16'd1276);

        repeat (5) @(negedge clk);
        #1;
        check("no_back_to_back", b2b, 0);
        check("total_pulses", pulses, exp_pulses);

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
